sw_reg_bank: RTL

//  Wishbone-slave bank of NUM_REGS software registers; successor to the single-register write block.
//  Per-register byte-enabled writes, read-only status registers sampled from fabric, per-register write strobes.

---
 rtl/sw_reg_pkg.sv | 29 ++
 rtl/sw_reg_be_merge.sv | 16 +
 rtl/sw_reg_bank.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_reg_pkg.sv
// Shared definitions for the software register bank: address helpers, FSM states
// and the location of the optional commit register.
package sw_reg_pkg;

  typedef enum logic {ST_IDLE, ST_RESP} sw_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of byte-address bits below the word index.
  function automatic int adr_lsb(input int byte_enables);
    return clog2(byte_enables);
  endfunction

  // The commit register occupies the first word past the register array.
  function automatic int commit_idx(input int num_regs);
    return num_regs;
  endfunction

endpackage

// File: rtl/sw_reg_be_merge.sv
// Byte-lane merge: each byte of the result comes from new_i when its sel bit is set,
// otherwise from old_i.
module sw_reg_be_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte
    assign merged_o[gi*8 +: 8] = sel_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
  end

endmodule

// File: rtl/sw_reg_bank.sv
// Wishbone slave bank of NUM_REGS software registers with read-only status slots.
// Define SW_REG_BANK_SHADOW_EN to stage writes in shadow registers released by a commit register.
module sw_reg_bank
  import sw_reg_pkg::*;
#(
  parameter logic [31:0]                         DEV_BASE_ADDR  = 32'd0,
  parameter int                                  BUS_DATA_WIDTH = 32,
  parameter int                                  BUS_ADDR_WIDTH = 8,
  parameter int                                  NUM_REGS       = 4,
  parameter logic [NUM_REGS-1:0]                 RO_MASK        = '0,
  parameter logic [NUM_REGS*BUS_DATA_WIDTH-1:0]  RESET_VAL      = '0
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_n_i,
  input  logic                                wbs_cyc_i,
  input  logic                                wbs_stb_i,
  input  logic                                wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]         wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]           wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]           wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]           wbs_dat_o,
  output logic                                wbs_ack_o,
  output logic                                wbs_err_o,
  output logic                                wbs_int_o,
  output logic [NUM_REGS*BUS_DATA_WIDTH-1:0]  fabric_data_o,
  output logic [NUM_REGS-1:0]                 fabric_wr_stb_o,
  input  logic [NUM_REGS*BUS_DATA_WIDTH-1:0]  fabric_status_i
);

  localparam int W   = BUS_DATA_WIDTH;
  localparam int BE  = BUS_DATA_WIDTH / 8;
  localparam int LSB = adr_lsb(BE);
  localparam logic [BUS_ADDR_WIDTH-1:0] BASE     = DEV_BASE_ADDR[BUS_ADDR_WIDTH-1:0];
  localparam logic [BUS_ADDR_WIDTH-1:0] LSB_MASK = BUS_ADDR_WIDTH'((1 << LSB) - 1);

  // ---------------------------------------------------------------- decode
  logic [BUS_ADDR_WIDTH-1:0] off;
  logic [BUS_ADDR_WIDTH-1:0] idx;
  logic [31:0]               idx32;
  logic                      in_range;
  logic                      aligned;
  logic                      hit;
  logic                      commit_hit;
  logic                      ro_hit;
  logic [NUM_REGS-1:0]       sel_reg;

  assign off      = wbs_adr_i - BASE;
  assign idx      = off >> LSB;
  assign idx32    = 32'(idx);
  assign in_range = 32'(wbs_adr_i) >= DEV_BASE_ADDR;
  assign aligned  = (off & LSB_MASK) == '0;
  assign hit      = in_range && aligned && (idx32 < 32'(NUM_REGS));
  assign ro_hit   = |(sel_reg & RO_MASK);

`ifdef SW_REG_BANK_SHADOW_EN
  localparam int CIDX = commit_idx(NUM_REGS);
  assign commit_hit = in_range && aligned && (idx32 == 32'(CIDX));
`else
  assign commit_hit = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  sw_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [W-1:0]      dat_q, dat_d;
  logic              accept;
  logic              wr_ok;
  logic              rd_ok;
  logic [W-1:0]      rd_val;
  logic [W-1:0]      reg_rd;
  logic [W-1:0]      rd_word [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;

  assign wr_ok = (hit && !ro_hit) || commit_hit;
  assign rd_ok = hit || commit_hit;

  always_comb begin
    reg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_reg[i]) reg_rd = rd_word[i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // A request is only taken in IDLE, so a held strobe yields one transfer per two cycles.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          accept  = 1'b1;
          state_d = ST_RESP;
          if (wbs_we_i) begin
            ack_d = wr_ok;
            err_d = !wr_ok;
          end else if (rd_ok) begin
            ack_d = 1'b1;
            dat_d = rd_val;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign wbs_int_o = 1'b0;

  // ---------------------------------------------------------------- registers
`ifdef SW_REG_BANK_SHADOW_EN
  logic [NUM_REGS-1:0] dirty;
  logic                pending;
  logic                commit_go;

  assign pending   = |dirty;
  assign commit_go = accept && wbs_we_i && commit_hit && wbs_sel_i[0] && wbs_dat_i[0];
  assign rd_val    = commit_hit ? {{(W-1){1'b0}}, pending} : reg_rd;
`else
  assign rd_val    = reg_rd;
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign sel_reg[gi] = hit && (idx32 == 32'(gi));
    assign wr_en[gi]   = accept && wbs_we_i && sel_reg[gi] && !RO_MASK[gi];

    if (RO_MASK[gi]) begin : g_ro
      assign rd_word[gi]                   = fabric_status_i[gi*W +: W];
      assign fabric_data_o[gi*W +: W]      = '0;
      assign fabric_wr_stb_o[gi]           = 1'b0;
`ifdef SW_REG_BANK_SHADOW_EN
      assign dirty[gi]                     = 1'b0;
`endif
    end else begin : g_rw
      logic         unused_status;
      logic [W-1:0] merged;
      logic         stb_q;

      assign unused_status = ^fabric_status_i[gi*W +: W];

`ifdef SW_REG_BANK_SHADOW_EN
      logic [W-1:0] shadow_q;
      logic [W-1:0] out_q;
      logic         dirty_q;

      sw_reg_be_merge #(.DATA_WIDTH(W)) u_merge (
        .old_i    (shadow_q),
        .new_i    (wbs_dat_i),
        .sel_i    (wbs_sel_i),
        .merged_o (merged)
      );

      // Writes and commits target different addresses, so they never collide.
      always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
          shadow_q <= RESET_VAL[gi*W +: W];
          out_q    <= RESET_VAL[gi*W +: W];
          dirty_q  <= 1'b0;
          stb_q    <= 1'b0;
        end else begin
          stb_q <= 1'b0;
          if (wr_en[gi]) begin
            shadow_q <= merged;
            dirty_q  <= 1'b1;
          end
          if (commit_go) begin
            out_q   <= shadow_q;
            stb_q   <= dirty_q;
            dirty_q <= 1'b0;
          end
        end
      end

      assign rd_word[gi]              = shadow_q;
      assign fabric_data_o[gi*W +: W] = out_q;
      assign dirty[gi]                = dirty_q;
`else
      logic [W-1:0] reg_q;

      sw_reg_be_merge #(.DATA_WIDTH(W)) u_merge (
        .old_i    (reg_q),
        .new_i    (wbs_dat_i),
        .sel_i    (wbs_sel_i),
        .merged_o (merged)
      );

      always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
          reg_q <= RESET_VAL[gi*W +: W];
          stb_q <= 1'b0;
        end else begin
          stb_q <= wr_en[gi];
          if (wr_en[gi]) reg_q <= merged;
        end
      end

      assign rd_word[gi]              = reg_q;
      assign fabric_data_o[gi*W +: W] = reg_q;
`endif
      assign fabric_wr_stb_o[gi] = stb_q;
    end
  end

endmodule
